// File: rtl/board_mem_arbiter_if.sv
// board_mem_arbiter_if
//   Bundles the four board clients' request/grant handshakes and the RAM-side
//   control lines of the gameboard memory arbiter.
//
//   Per client x in {init, flip, vali, vga}:
//     req_x     client requests the RAM, held for the whole access burst
//     addr_x    client address
//     data_x    client write data
//     wren_x    client write enable
//     gnt_x     grant (one-hot or all zero)
//     rvalid_x  RAM q holds client x read data this cycle
//   RAM side:
//     addr_out, data_out, wren_out  muxed RAM controls
//     busy                          any grant held
//
//   Modports: master = client/RAM side (drives requests), slave = arbiter.
interface board_mem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 2
);
  logic              req_init, req_flip, req_vali, req_vga;
  logic [ADDR_W-1:0] addr_init, addr_flip, addr_vali, addr_vga;
  logic [DATA_W-1:0] data_init, data_flip, data_vali, data_vga;
  logic              wren_init, wren_flip, wren_vali, wren_vga;
  logic              gnt_init, gnt_flip, gnt_vali, gnt_vga;
  logic              rvalid_init, rvalid_flip, rvalid_vali, rvalid_vga;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              wren_out;
  logic              busy;

  modport master (
    output req_init, req_flip, req_vali, req_vga,
    output addr_init, addr_flip, addr_vali, addr_vga,
    output data_init, data_flip, data_vali, data_vga,
    output wren_init, wren_flip, wren_vali, wren_vga,
    input  gnt_init, gnt_flip, gnt_vali, gnt_vga,
    input  rvalid_init, rvalid_flip, rvalid_vali, rvalid_vga,
    input  addr_out, data_out, wren_out, busy
  );

  modport slave (
    input  req_init, req_flip, req_vali, req_vga,
    input  addr_init, addr_flip, addr_vali, addr_vga,
    input  data_init, data_flip, data_vali, data_vga,
    input  wren_init, wren_flip, wren_vali, wren_vga,
    output gnt_init, gnt_flip, gnt_vali, gnt_vga,
    output rvalid_init, rvalid_flip, rvalid_vali, rvalid_vga,
    output addr_out, data_out, wren_out, busy
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter
//   Request/grant arbiter for the single-port 128 x 2-bit gameboard RAM shared
//   by the initializer, flipper, validator and VGA scanner. A granted client
//   keeps the RAM until it drops its request; release and re-grant happen on
//   the same edge. Read-valid strobes line up with the RAM's one-cycle read
//   latency. A starvation counter promotes the VGA scanner above flip/vali
//   once it has waited STARVE_LIMIT cycles.
//
//   Ports:
//     clock  system clock, all state on the rising edge
//     reset  asynchronous, active-low reset
//     bus    board_mem_arbiter_if.slave (client handshakes + RAM controls)
module board_mem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 2,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  board_mem_arbiter_if.slave    bus
);

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_INIT,
    OWN_FLIP,
    OWN_VALI,
    OWN_VGA
  } owner_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  owner_t     owner_q, owner_d;
  logic [7:0] starve_cnt, starve_d;
  logic       owner_req;
  logic       promote;

  assign promote = (starve_cnt == LIMIT);

  // Request line of whoever currently owns the RAM.
  always_comb begin
    owner_req = 1'b0;
    case (owner_q)
      OWN_INIT: owner_req = bus.req_init;
      OWN_FLIP: owner_req = bus.req_flip;
      OWN_VALI: owner_req = bus.req_vali;
      OWN_VGA:  owner_req = bus.req_vga;
      default:  owner_req = 1'b0;
    endcase
  end

  // Arbitrate only when the RAM is free or the owner is letting go, so a new
  // winner takes over on the very edge the owner releases.
  always_comb begin
    owner_d = owner_q;
    if (owner_q == OWN_NONE || !owner_req) begin
      if (bus.req_init)                owner_d = OWN_INIT;
      else if (promote && bus.req_vga) owner_d = OWN_VGA;
      else if (bus.req_flip)           owner_d = OWN_FLIP;
      else if (bus.req_vali)           owner_d = OWN_VALI;
      else if (bus.req_vga)            owner_d = OWN_VGA;
      else                             owner_d = OWN_NONE;
    end
  end

  // Counts cycles VGA has been waiting; any gap in its request or a grant
  // restarts the count.
  always_comb begin
    starve_d = starve_cnt;
    if (!bus.req_vga || owner_q == OWN_VGA)
      starve_d = 8'd0;
    else if (starve_cnt < LIMIT)
      starve_d = starve_cnt + 8'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_NONE;
      starve_cnt <= 8'd0;
    end else begin
      owner_q    <= owner_d;
      starve_cnt <= starve_d;
    end
  end

  // Grants decode straight from the owner flop, so they change only at edges
  // (or on reset) and are one-hot by construction.
  assign bus.gnt_init = (owner_q == OWN_INIT);
  assign bus.gnt_flip = (owner_q == OWN_FLIP);
  assign bus.gnt_vali = (owner_q == OWN_VALI);
  assign bus.gnt_vga  = (owner_q == OWN_VGA);
  assign bus.busy     = (owner_q != OWN_NONE);

  // A read presented this cycle appears on RAM q next cycle; flag it then.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.rvalid_init <= 1'b0;
      bus.rvalid_flip <= 1'b0;
      bus.rvalid_vali <= 1'b0;
      bus.rvalid_vga  <= 1'b0;
    end else begin
      bus.rvalid_init <= bus.gnt_init & bus.req_init & ~bus.wren_init;
      bus.rvalid_flip <= bus.gnt_flip & bus.req_flip & ~bus.wren_flip;
      bus.rvalid_vali <= bus.gnt_vali & bus.req_vali & ~bus.wren_vali;
      bus.rvalid_vga  <= bus.gnt_vga  & bus.req_vga  & ~bus.wren_vga;
    end
  end

  // RAM control mux. Write enable is gated by the owner's live request so a
  // write is suppressed in the cycle the owner drops out.
  always_comb begin
    bus.addr_out = '0;
    bus.data_out = '0;
    bus.wren_out = 1'b0;
    case (owner_q)
      OWN_INIT: begin
        bus.addr_out = bus.addr_init;
        bus.data_out = bus.data_init;
        bus.wren_out = bus.wren_init & bus.req_init;
      end
      OWN_FLIP: begin
        bus.addr_out = bus.addr_flip;
        bus.data_out = bus.data_flip;
        bus.wren_out = bus.wren_flip & bus.req_flip;
      end
      OWN_VALI: begin
        bus.addr_out = bus.addr_vali;
        bus.data_out = bus.data_vali;
        bus.wren_out = bus.wren_vali & bus.req_vali;
      end
      OWN_VGA: begin
        bus.addr_out = bus.addr_vga;
        bus.data_out = bus.data_vga;
        bus.wren_out = bus.wren_vga & bus.req_vga;
      end
      default: begin
        bus.addr_out = '0;
        bus.data_out = '0;
        bus.wren_out = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Arbitrates the single-port gameboard RAM (128 × 2-bit) among the four board clients: initializer, flipper, validator and VGA scanner. It replaces the static control-line mux with a registered request/grant handshake. A granted client keeps ownership until it drops its request, and read-data valid strobes are aligned to the RAM's one-cycle read latency. A starvation counter guarantees the VGA scanner eventual access while a move is being validated and flipped.

## Interface
Parameters:
- ADDR_W, 7, RAM address width
- DATA_W, 2, RAM word width (00 empty, 01/10 player pieces)
- STARVE_LIMIT, 64, waiting cycles after which VGA is promoted; range 1..255

Ports (x ∈ {init, flip, vali, vga}):
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_x  in  1  client x requests the RAM; held for the whole access burst
- addr_x  in  ADDR_W  client x address
- data_x  in  DATA_W  client x write data
- wren_x  in  1  client x write enable
- gnt_x  out  1  registered grant; one-hot or all zero
- rvalid_x  out  1  RAM q holds client x read data this cycle
- addr_out  out  ADDR_W  to RAM address
- data_out  out  DATA_W  to RAM data
- wren_out  out  1  to RAM wren
- busy  out  1  any grant held

## Operation
- State: owner register (NONE, INIT, FLIP, VALI, VGA), starve counter (8 bit), four rvalid flops.
- Arbitration happens at each rising edge when owner = NONE or the current owner's req is low. Candidates are clients with req high.
- Priority: init > flip > vali > vga. If starve = STARVE_LIMIT, the order becomes init > vga > flip > vali.
- No preemption. The owner keeps the grant while its req stays high, even if init requests.
- Release and re-grant happen on the same edge with no bubble: when the owner's req is low at the edge, the new winner (if any) is granted at that edge. Otherwise owner becomes NONE.
- Output mux is combinational from the owner:
  - addr_out = addr_owner, data_out = data_owner.
  - wren_out = wren_owner & req_owner. A write is masked the instant the owner drops req.
  - With owner = NONE: addr_out = 0, data_out = 0, wren_out = 0.
- Read strobe: rvalid_x <= gnt_x & req_x & ~wren_x. It is high exactly in the cycle the RAM q reflects the address presented in the previous cycle.
- Starve counter:
  - Increments each edge where req_vga = 1 and gnt_vga = 0, saturating at STARVE_LIMIT.
  - Clears to 0 on any edge where gnt_vga is 1 or req_vga is 0.
- busy = (owner ≠ NONE).

## Timing
- Reset (reset = 0, asynchronous): owner = NONE, all gnt_x = 0, all rvalid_x = 0, starve = 0, busy = 0, addr_out/data_out/wren_out = 0. Reset asserted mid-burst aborts the grant immediately, and any in-flight rvalid is dropped.
- Grant latency: req_x rising before edge N with RAM free → gnt_x high after edge N. The first access cycle is the cycle following edge N.
- Read latency: address presented in cycle k (gnt_x & req_x & ~wren_x) → rvalid_x and valid q in cycle k+1.
- Write: takes effect at the edge ending the cycle with gnt_x & req_x & wren_x.
- Release: owner deasserts req before edge M → gnt drops after edge M, and the next winner's gnt rises after the same edge M.
- Simultaneous requests at an idle edge resolve by the priority order. Exactly one gnt rises.
- Client dropping req without ever being granted: no effect. The starve counter clears if that client is VGA.
- Worst-case VGA wait: STARVE_LIMIT cycles plus the remaining burst of the current owner, plus one init burst.

## Test plan
- Reset: hold reset = 0 with all req = 1 → every gnt/rvalid/wren_out = 0 and addr_out = 0. Release reset → gnt_init = 1 after the first edge.
- Priority: req_flip, req_vali and req_vga all rise in the same cycle → gnt_flip first. Flip drops req → gnt_vali on the same edge. Vali drops req → gnt_vga.
- Read latency: vali granted, addr_vali = 27 (board holds 01) → rvalid_vali = 1 and q = 01 exactly one cycle later. No rvalid on write cycles.
- Write masking: flip granted with wren_flip = 1, data 10 at addr 36, then req dropped in the same cycle wren stays high → wren_out = 0, and the RAM at 36 is unchanged.
- Starvation: hold req_vga = 1 while flip/vali alternate bursts back-to-back with STARVE_LIMIT = 4 → vga granted at the first release after 4 waiting cycles, ahead of a pending vali. Starve returns to 0.
- Reset mid-burst: assert reset while vga is granted with rvalid pending → gnt_vga and rvalid_vga fall immediately (asynchronously, same cycle) and stay low until reset is released.
